alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
Multi-cycle datapath controller that drives the Lab5 ALU from its operand side. It accepts one register-to-register operation request through a valid/ready handshake and reads two source registers from an internal register file. It routes the second operand through a shifter, presents the operands and ALUop to the external ALU, captures the result and Z flag, and optionally writes the result back. It sits between the instruction/control layer and the existing ALU.

Parameters:
W, 16, datapath and register width.
NREG, 8, register count; register index width is AW = clog2(NREG) = 3.

Ports:
clk  in  1  rising-edge clock.
reset  in  1  synchronous, active-high reset.
req_valid  in  1  operation request present.
req_ready  out  1  high only in IDLE.
req_op  in  2  ALUop: 00 add, 01 sub, 10 and, 11 not-B.
req_rn  in  AW  source A register index.
req_rm  in  AW  source B register index.
req_rd  in  AW  destination register index.
req_shift  in  2  B shift: 00 none, 01 left by 1, 10 logical right by 1, 11 arithmetic right by 1.
req_wb  in  1  write result to R[rd] when 1.
ld_en  in  1  direct register load; honoured only in IDLE.
ld_addr  in  AW  load index.
ld_data  in  W  load value.
alu_ain  out  W  to ALU Ain; equals A register.
alu_bin  out  W  to ALU Bin; equals B register.
alu_op  out  2  to ALU ALUop; equals latched op.
alu_out  in  W  ALU result.
alu_z  in  1  ALU zero flag.
done  out  1  one-cycle pulse while in WB.
result  out  W  C register (last captured ALU result).
status_z  out  1  Z captured with C.
dbg_addr  in  AW  debug read index.
dbg_data  out  W  combinational R[dbg_addr].

Behaviour:
- States: IDLE, LOAD_A, LOAD_B, EXEC, WB.
- Reset (synchronous, priority over everything): state=IDLE; A, B, C=0; status_z=0; latched op/rn/rm/rd/shift/wb=0; all NREG registers=0; done=0; req_ready=1 on the first cycle after reset.
- IDLE: req_ready=1. On an edge with req_valid=1, latch all req_* fields and go to LOAD_A. With req_valid=0, stay in IDLE.
- LOAD_A: A <= R[rn]; go to LOAD_B.
- LOAD_B: B <= shift(R[rm]); go to EXEC.
  - Left shift fills LSB with 0.
  - Logical right shift fills MSB with 0.
  - Arithmetic right shift replicates the MSB.
- EXEC: the ALU sees A, B and op for the full cycle. At the edge, C <= alu_out and status_z <= alu_z; go to WB.
- WB: done=1. At the edge, if wb=1 then R[rd] <= C. Return to IDLE.
- Latency: request accepted at edge E0; done high in the cycle between E3 and E4; the register file is updated at E4. A back-to-back request can be accepted at E5 at the earliest. Throughput is one operation per 5 cycles.
- req_valid while not IDLE: ignored and not latched; the requester must hold req_valid until it sees ready.
- ld_en outside IDLE: ignored.
- ld_en with an accepted request in the same IDLE cycle: both take effect. The load writes at E0, so a LOAD_A/LOAD_B read of the same index sees ld_data.
- rd equal to rn or rm: legal. Sources are read before write-back.
- wb=0: register file unchanged; C and status_z are still updated.
- Arithmetic wraps modulo 2^W; no carry or overflow outputs.
- Reset mid-operation: aborts immediately with no write-back, and done stays 0.
- alu_ain, alu_bin and alu_op are driven from registers at all times (no combinational path from req_*).

Decomposition:
- Shared package: ALUop encodings (ADD=00, SUB=01, AND=10, NOTB=11), shift encodings, FSM state enum, W and NREG defaults.
- One sub-module, regfile_rw: NREG x W array, one synchronous write port (muxed between ld and WB, with the ld path used only in IDLE) and two combinational read ports (datapath and debug).
- The shifter stays inline.

Test Plan:
- Load R0=0x0003 and R1=0x0003; ADD rn=0, rm=1, rd=2, wb=1 -> done 4 edges after accept; result=0x0006, status_z=0, R2=0x0006.
- SUB rn=0, rm=1, rd=2, wb=0 -> result=0x0000, status_z=1, R2 still 0x0006.
- Shift:
  - ADD rn=0, rm=1, shift=01, rd=3 -> B=0x0006, R3=0x0009.
  - Load R4=0x8002; NOTB rm=4, shift=11, rd=5 -> B=0xC001, R5=0x3FFE.
- AND rn=0, rm=1, rd=0 -> R0=0x0003; then NOTB rm=1, rd=6 -> R6=0xFFFC, status_z=0.
- Backpressure: hold req_valid with a different op during LOAD_A..WB -> only the first request executes; the second is accepted at the first IDLE edge. ld_en during EXEC leaves the register unchanged.
- Assert reset for 1 cycle during EXEC of ADD rd=7 -> R7=0, no done pulse, result=0, status_z=0, req_ready=1 next cycle.

Source files
------------

// File: rtl/alu_op_sequencer_pkg.sv
// rtl/alu_op_sequencer_pkg.sv - shared encodings and defaults for the ALU operand sequencer
package alu_op_sequencer_pkg;

  localparam int W_DEF    = 16;
  localparam int NREG_DEF = 8;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_AND  = 2'b10,
    OP_NOTB = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    SH_NONE = 2'b00,
    SH_LSL  = 2'b01,
    SH_LSR  = 2'b10,
    SH_ASR  = 2'b11
  } shift_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4
  } state_e;

endpackage

// File: rtl/alu_op_sequencer_regfile_rw.sv
// rtl/alu_op_sequencer_regfile_rw.sv - register file with one muxed write port and two read ports
module regfile_rw #(
  parameter int W    = 16,
  parameter int NREG = 8,
  parameter int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [W-1:0]  ld_data,
  input  logic          wb_we,
  input  logic [AW-1:0] wb_addr,
  input  logic [W-1:0]  wb_data,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data,
  input  logic [AW-1:0] dbg_addr,
  output logic [W-1:0]  dbg_data
);

  logic [W-1:0] regs [NREG];

  // Single write port: direct loads only occur in IDLE and write-back only in WB,
  // so the two sources never collide; load is given priority regardless.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (ld_we) begin
      regs[ld_addr] <= ld_data;
    end else if (wb_we) begin
      regs[wb_addr] <= wb_data;
    end
  end

  assign rd_data  = regs[rd_addr];
  assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - multi-cycle operand sequencer feeding an external ALU
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter int W    = W_DEF,
  parameter int NREG = NREG_DEF,
  parameter int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [1:0]    req_op,
  input  logic [AW-1:0] req_rn,
  input  logic [AW-1:0] req_rm,
  input  logic [AW-1:0] req_rd,
  input  logic [1:0]    req_shift,
  input  logic          req_wb,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [W-1:0]  ld_data,
  output logic [W-1:0]  alu_ain,
  output logic [W-1:0]  alu_bin,
  output logic [1:0]    alu_op,
  input  logic [W-1:0]  alu_out,
  input  logic          alu_z,
  output logic          done,
  output logic [W-1:0]  result,
  output logic          status_z,
  input  logic [AW-1:0] dbg_addr,
  output logic [W-1:0]  dbg_data
);

  state_e        state, next_state;
  logic [W-1:0]  a_q, b_q, c_q;
  logic          z_q;
  logic [1:0]    op_q;
  logic [AW-1:0] rn_q, rm_q, rd_q;
  shift_e        shift_q;
  logic          wb_q;

  logic          latch_req, load_a, load_b, capture_c, wb_fire;
  logic [AW-1:0] rf_raddr;
  logic [W-1:0]  rf_rdata, b_shifted;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // Next-state and per-state control strobes
  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    done       = 1'b0;
    latch_req  = 1'b0;
    load_a     = 1'b0;
    load_b     = 1'b0;
    capture_c  = 1'b0;
    wb_fire    = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          latch_req  = 1'b1;
          next_state = S_LOAD_A;
        end
      end
      S_LOAD_A: begin
        load_a     = 1'b1;
        next_state = S_LOAD_B;
      end
      S_LOAD_B: begin
        load_b     = 1'b1;
        next_state = S_EXEC;
      end
      S_EXEC: begin
        capture_c  = 1'b1;
        next_state = S_WB;
      end
      S_WB: begin
        done       = 1'b1;
        wb_fire    = wb_q;
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // The single datapath read port serves rn in LOAD_A and rm in LOAD_B
  assign rf_raddr = (state == S_LOAD_B) ? rm_q : rn_q;

  // Inline B-operand shifter
  always_comb begin
    b_shifted = rf_rdata;
    case (shift_q)
      SH_LSL:  b_shifted = {rf_rdata[W-2:0], 1'b0};
      SH_LSR:  b_shifted = {1'b0, rf_rdata[W-1:1]};
      SH_ASR:  b_shifted = {rf_rdata[W-1], rf_rdata[W-1:1]};
      default: b_shifted = rf_rdata;
    endcase
  end

  // Request latch and operand/result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      z_q     <= 1'b0;
      op_q    <= 2'b00;
      rn_q    <= '0;
      rm_q    <= '0;
      rd_q    <= '0;
      shift_q <= SH_NONE;
      wb_q    <= 1'b0;
    end else begin
      if (latch_req) begin
        op_q    <= req_op;
        rn_q    <= req_rn;
        rm_q    <= req_rm;
        rd_q    <= req_rd;
        shift_q <= shift_e'(req_shift);
        wb_q    <= req_wb;
      end
      if (load_a) a_q <= rf_rdata;
      if (load_b) b_q <= b_shifted;
      if (capture_c) begin
        c_q <= alu_out;
        z_q <= alu_z;
      end
    end
  end

  regfile_rw #(.W(W), .NREG(NREG), .AW(AW)) u_regfile (
    .clk      (clk),
    .reset    (reset),
    .ld_we    (ld_en && (state == S_IDLE)),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .wb_we    (wb_fire),
    .wb_addr  (rd_q),
    .wb_data  (c_q),
    .rd_addr  (rf_raddr),
    .rd_data  (rf_rdata),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  assign alu_ain  = a_q;
  assign alu_bin  = b_q;
  assign alu_op   = op_q;
  assign result   = c_q;
  assign status_z = z_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - directed self-checking bench for alu_op_sequencer
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [2:0]  req_rn, req_rm, req_rd;
  logic [1:0]  req_shift;
  logic        req_wb;
  logic        ld_en;
  logic [2:0]  ld_addr;
  logic [15:0] ld_data;
  logic [15:0] alu_ain, alu_bin;
  logic [1:0]  alu_op;
  logic [15:0] alu_out;
  logic        alu_z;
  logic        done;
  logic [15:0] result;
  logic        status_z;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;

  int n_cmp = 0;
  int n_bad = 0;

  int          lat;
  logic [15:0] seen_bin;
  logic [1:0]  seen_op;
  int          done_cnt;

  always #5 clk = ~clk;

  // Reference model of the external Lab5 ALU
  always_comb begin
    case (alu_op)
      2'b00:   alu_out = alu_ain + alu_bin;
      2'b01:   alu_out = alu_ain - alu_bin;
      2'b10:   alu_out = alu_ain & alu_bin;
      default: alu_out = ~alu_bin;
    endcase
    alu_z = (alu_out == 16'h0000);
  end

  alu_op_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_rn    (req_rn),
    .req_rm    (req_rm),
    .req_rd    (req_rd),
    .req_shift (req_shift),
    .req_wb    (req_wb),
    .ld_en     (ld_en),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .alu_ain   (alu_ain),
    .alu_bin   (alu_bin),
    .alu_op    (alu_op),
    .alu_out   (alu_out),
    .alu_z     (alu_z),
    .done      (done),
    .result    (result),
    .status_z  (status_z),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reg(input string tag, input logic [2:0] idx, input logic [15:0] exp);
    dbg_addr = idx;
    #1;
    check(tag, {16'h0, dbg_data}, {16'h0, exp});
  endtask

  task automatic load_reg(input logic [2:0] idx, input logic [15:0] val);
    ld_en   = 1'b1;
    ld_addr = idx;
    ld_data = val;
    @(negedge clk);
    ld_en   = 1'b0;
  endtask

  task automatic present(input logic [1:0] op, input logic [2:0] rn, input logic [2:0] rm,
                         input logic [2:0] rd, input logic [1:0] sh, input logic wb);
    req_op    = op;
    req_rn    = rn;
    req_rm    = rm;
    req_rd    = rd;
    req_shift = sh;
    req_wb    = wb;
    req_valid = 1'b1;
  endtask

  // Called at the negedge right after the accepting edge; returns how many edges
  // after acceptance done was seen (bounded), plus B/op as seen during EXEC.
  task automatic wait_done(input bit poke_ld, output int n, output logic [15:0] bin,
                           output logic [1:0] op);
    n   = 1;
    bin = 'x;
    op  = 'x;
    while (done !== 1'b1 && n < 10) begin
      if (n == 3) begin
        bin = alu_bin;
        op  = alu_op;
        if (poke_ld) begin
          ld_en   = 1'b1;
          ld_addr = 3'd6;
          ld_data = 16'h1234;
        end
      end
      @(negedge clk);
      n++;
      ld_en = 1'b0;
    end
  endtask

  task automatic run_op(input logic [1:0] op, input logic [2:0] rn, input logic [2:0] rm,
                        input logic [2:0] rd, input logic [1:0] sh, input logic wb);
    present(op, rn, rm, rd, sh, wb);
    @(negedge clk);
    req_valid = 1'b0;
    wait_done(1'b0, lat, seen_bin, seen_op);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_rn = '0; req_rm = '0; req_rd = '0;
    req_shift = 2'b00; req_wb = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0; dbg_addr = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    check("rst_ready", {31'h0, req_ready}, 32'h1);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_result", {16'h0, result}, 32'h0);
    check("rst_z", {31'h0, status_z}, 32'h0);
    check("rst_ain", {16'h0, alu_ain}, 32'h0);
    check("rst_bin", {16'h0, alu_bin}, 32'h0);
    check("rst_op", {30'h0, alu_op}, 32'h0);
    check_reg("rst_r0", 3'd0, 16'h0000);

    load_reg(3'd0, 16'h0003);
    load_reg(3'd1, 16'h0003);
    check_reg("ld_r0", 3'd0, 16'h0003);
    check_reg("ld_r1", 3'd1, 16'h0003);

    run_op(2'b00, 3'd0, 3'd1, 3'd2, 2'b00, 1'b1);
    check("add_latency", lat, 32'd4);
    check("add_result", {16'h0, result}, 32'h0006);
    check("add_z", {31'h0, status_z}, 32'h0);
    @(negedge clk);
    check_reg("add_r2", 3'd2, 16'h0006);

    run_op(2'b01, 3'd0, 3'd1, 3'd2, 2'b00, 1'b0);
    check("sub_latency", lat, 32'd4);
    check("sub_result", {16'h0, result}, 32'h0000);
    check("sub_z", {31'h0, status_z}, 32'h1);
    @(negedge clk);
    check_reg("sub_nowb_r2", 3'd2, 16'h0006);

    run_op(2'b00, 3'd0, 3'd1, 3'd3, 2'b01, 1'b1);
    check("lsl_bin", {16'h0, seen_bin}, 32'h0006);
    @(negedge clk);
    check_reg("lsl_r3", 3'd3, 16'h0009);

    load_reg(3'd4, 16'h8002);
    run_op(2'b11, 3'd0, 3'd4, 3'd5, 2'b11, 1'b1);
    check("asr_bin", {16'h0, seen_bin}, 32'hC001);
    check("notb_result", {16'h0, result}, 32'h3FFE);
    @(negedge clk);
    check_reg("asr_r5", 3'd5, 16'h3FFE);

    run_op(2'b10, 3'd0, 3'd1, 3'd0, 2'b00, 1'b1);
    @(negedge clk);
    check_reg("and_r0", 3'd0, 16'h0003);
    run_op(2'b11, 3'd0, 3'd1, 3'd6, 2'b00, 1'b1);
    check("notb_z", {31'h0, status_z}, 32'h0);
    @(negedge clk);
    check_reg("notb_r6", 3'd6, 16'hFFFC);

    // Backpressure: SUB R4 = R3 - R0 = 6, then a held AND R5 = R3 & R0 = 1
    present(2'b01, 3'd3, 3'd0, 3'd4, 2'b00, 1'b1);
    @(negedge clk);
    present(2'b10, 3'd3, 3'd0, 3'd5, 2'b00, 1'b1);
    wait_done(1'b0, lat, seen_bin, seen_op);
    check("bp_first_latency", lat, 32'd4);
    check("bp_first_op", {30'h0, seen_op}, 32'h1);
    check("bp_first_result", {16'h0, result}, 32'h0006);
    @(negedge clk);
    check("bp_ready_idle", {31'h0, req_ready}, 32'h1);
    check_reg("bp_r4", 3'd4, 16'h0006);
    check_reg("bp_r5_before", 3'd5, 16'h3FFE);
    @(negedge clk);
    check("bp_ready_busy", {31'h0, req_ready}, 32'h0);
    req_valid = 1'b0;
    wait_done(1'b1, lat, seen_bin, seen_op);
    check("bp_second_latency", lat, 32'd4);
    check("bp_second_op", {30'h0, seen_op}, 32'h2);
    check("bp_second_result", {16'h0, result}, 32'h0001);
    @(negedge clk);
    check_reg("bp_r5_after", 3'd5, 16'h0001);
    check_reg("ld_in_exec_r6", 3'd6, 16'hFFFC);

    // Reset during EXEC of ADD rd=7
    present(2'b00, 3'd0, 3'd1, 3'd7, 2'b00, 1'b1);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_ready", {31'h0, req_ready}, 32'h1);
    check("mid_rst_done", {31'h0, done}, 32'h0);
    check("mid_rst_result", {16'h0, result}, 32'h0);
    check("mid_rst_z", {31'h0, status_z}, 32'h0);
    check_reg("mid_rst_r0", 3'd0, 16'h0000);
    done_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
    end
    check("mid_rst_no_done", done_cnt, 32'd0);
    check_reg("mid_rst_r7", 3'd7, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
